// File: rtl/ppc_types.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ppc_types : shared decode and reservation-station types       rev 1.0
// ----------------------------------------------------------------------------
package ppc_types;

    localparam int RS_TAG_MAX_W = 8;
    localparam int RS_AGE_MAX_W = 3;

    typedef enum logic [1:0] {
        DIV_OP_DIVW   = 2'd0,
        DIV_OP_DIVWU  = 2'd1,
        DIV_OP_DIVWE  = 2'd2,
        DIV_OP_DIVWEU = 2'd3
    } div_op_e;

    typedef struct packed {
        div_op_e op;
        logic    oe;
        logic    rc;
    } div_decode_t;

    // Tags are held zero-extended to the widest supported tag width.
    typedef struct packed {
        logic                    busy;
        logic                    op1_rdy;
        logic [RS_TAG_MAX_W-1:0] op1_tag;
        logic [31:0]             op1;
        logic                    op2_rdy;
        logic [RS_TAG_MAX_W-1:0] op2_tag;
        logic [31:0]             op2;
        logic                    xer_rdy;
        logic [RS_TAG_MAX_W-1:0] xer_tag;
        logic [31:0]             xer;
        logic [4:0]              result_reg_addr;
        div_decode_t             control;
        logic [RS_AGE_MAX_W-1:0] age;
    } rs_entry_div_t;

    function automatic logic rs_cdb_hit(input logic                    rdy,
                                        input logic [RS_TAG_MAX_W-1:0] tag,
                                        input logic                    cdb_v,
                                        input logic [RS_TAG_MAX_W-1:0] cdb_t);
        return !rdy && cdb_v && (tag == cdb_t);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_rs_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// div_rs_if : dispatch / CDB / issue bundle of the divide RS     rev 1.0
// ----------------------------------------------------------------------------
interface div_rs_if
    import ppc_types::*;
#(
    parameter int RS_ID_WIDTH = 5
);
    logic                   dispatch_valid;
    logic                   dispatch_ready;
    logic [4:0]             result_reg_addr_in;
    div_decode_t            control_in;
    logic [31:0]            op1_in;
    logic [31:0]            op2_in;
    logic [31:0]            xer_in;
    logic                   op1_rdy_in;
    logic                   op2_rdy_in;
    logic                   xer_rdy_in;
    logic [RS_ID_WIDTH-1:0] op1_tag_in;
    logic [RS_ID_WIDTH-1:0] op2_tag_in;
    logic [RS_ID_WIDTH-1:0] xer_tag_in;
    logic                   cdb_valid;
    logic [RS_ID_WIDTH-1:0] cdb_rs_id;
    logic [31:0]            cdb_result;
    logic [31:0]            cdb_xer;
    logic                   issue_valid;
    logic                   issue_ready;
    logic [RS_ID_WIDTH-1:0] rs_id_out;
    logic [4:0]             result_reg_addr_out;
    logic [31:0]            op1;
    logic [31:0]            op2;
    logic [31:0]            xer;
    div_decode_t            control;

    modport slave (
        input  dispatch_valid, result_reg_addr_in, control_in,
        input  op1_in, op2_in, xer_in, op1_rdy_in, op2_rdy_in, xer_rdy_in,
        input  op1_tag_in, op2_tag_in, xer_tag_in,
        input  cdb_valid, cdb_rs_id, cdb_result, cdb_xer, issue_ready,
        output dispatch_ready, issue_valid, rs_id_out, result_reg_addr_out,
        output op1, op2, xer, control
    );

    modport master (
        output dispatch_valid, result_reg_addr_in, control_in,
        output op1_in, op2_in, xer_in, op1_rdy_in, op2_rdy_in, xer_rdy_in,
        output op1_tag_in, op2_tag_in, xer_tag_in,
        output cdb_valid, cdb_rs_id, cdb_result, cdb_xer, issue_ready,
        input  dispatch_ready, issue_valid, rs_id_out, result_reg_addr_out,
        input  op1, op2, xer, control
    );
endinterface
`default_nettype wire

// File: rtl/div_rs_age_select.sv
`default_nettype none
// ----------------------------------------------------------------------------
// age_select : picks the eligible entry with the smallest age    rev 1.0
// ----------------------------------------------------------------------------
module age_select #(
    parameter int ENTRIES = 4,
    parameter int AGE_W   = 3,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  wire logic [ENTRIES-1:0]       eligible_i,
    input  wire logic [ENTRIES*AGE_W-1:0] age_i,
    output logic                          valid_o,
    output logic [IDX_W-1:0]              idx_o
);
    logic [AGE_W-1:0] best_age_w;

    // Ages of busy entries are unique, so the minimum is unambiguous.
    always_comb begin
        valid_o    = 1'b0;
        idx_o      = '0;
        best_age_w = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (eligible_i[i] && (!valid_o || (age_i[i*AGE_W +: AGE_W] < best_age_w))) begin
                valid_o    = 1'b1;
                idx_o      = IDX_W'(i);
                best_age_w = age_i[i*AGE_W +: AGE_W];
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/div_rs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// div_rs : divide-unit reservation station, oldest-ready issue   rev 1.0
// ----------------------------------------------------------------------------
module div_rs
    import ppc_types::*;
#(
    parameter int RS_ID_WIDTH = 5,
    parameter int ENTRIES     = 4,
    parameter int RS_BASE_ID  = 0
) (
    input  wire logic clk,
    input  wire logic rst,
    div_rs_if.slave   bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = IDX_W + 1;

    rs_entry_div_t entries_q [ENTRIES];
    rs_entry_div_t entries_d [ENTRIES];

    logic [ENTRIES-1:0]              busy_w;
    logic [ENTRIES-1:0]              elig_w;
    logic [ENTRIES*RS_AGE_MAX_W-1:0] ages_w;
    logic                            sel_valid_w;
    logic [IDX_W-1:0]                sel_idx_w;
    logic [RS_AGE_MAX_W-1:0]         sel_age_w;
    logic [IDX_W-1:0]                free_idx_w;
    logic                            free_found_w;
    logic [CNT_W-1:0]                busy_cnt_w;
    logic                            issue_fire_w;
    logic                            dispatch_fire_w;
    logic [RS_TAG_MAX_W-1:0]         cdb_tag_w;
    rs_entry_div_t                   new_entry_w;

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_flags
        assign busy_w[gi] = entries_q[gi].busy;
        assign elig_w[gi] = entries_q[gi].busy & entries_q[gi].op1_rdy &
                            entries_q[gi].op2_rdy & entries_q[gi].xer_rdy;
        assign ages_w[gi*RS_AGE_MAX_W +: RS_AGE_MAX_W] = entries_q[gi].age;
    end

    age_select #(
        .ENTRIES (ENTRIES),
        .AGE_W   (RS_AGE_MAX_W),
        .IDX_W   (IDX_W)
    ) u_age_select (
        .eligible_i (elig_w),
        .age_i      (ages_w),
        .valid_o    (sel_valid_w),
        .idx_o      (sel_idx_w)
    );

    always_comb begin
        free_found_w = 1'b0;
        free_idx_w   = '0;
        busy_cnt_w   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!busy_w[i]) begin
                free_found_w = 1'b1;
                free_idx_w   = IDX_W'(i);
            end
            busy_cnt_w = busy_cnt_w + CNT_W'(busy_w[i]);
        end
    end

    assign cdb_tag_w       = RS_TAG_MAX_W'(bus.cdb_rs_id);
    assign sel_age_w       = entries_q[sel_idx_w].age;
    assign issue_fire_w    = sel_valid_w & bus.issue_ready;
    assign dispatch_fire_w = bus.dispatch_valid & free_found_w;

    // Age counts the older busy entries, so a new entry's age is the
    // occupancy left after this cycle's issue.
    always_comb begin
        new_entry_w                 = '0;
        new_entry_w.busy            = 1'b1;
        new_entry_w.op1_tag         = RS_TAG_MAX_W'(bus.op1_tag_in);
        new_entry_w.op2_tag         = RS_TAG_MAX_W'(bus.op2_tag_in);
        new_entry_w.xer_tag         = RS_TAG_MAX_W'(bus.xer_tag_in);
        new_entry_w.op1_rdy         = bus.op1_rdy_in |
            rs_cdb_hit(1'b0, new_entry_w.op1_tag, bus.cdb_valid, cdb_tag_w);
        new_entry_w.op2_rdy         = bus.op2_rdy_in |
            rs_cdb_hit(1'b0, new_entry_w.op2_tag, bus.cdb_valid, cdb_tag_w);
        new_entry_w.xer_rdy         = bus.xer_rdy_in |
            rs_cdb_hit(1'b0, new_entry_w.xer_tag, bus.cdb_valid, cdb_tag_w);
        new_entry_w.op1             = bus.op1_rdy_in ? bus.op1_in : bus.cdb_result;
        new_entry_w.op2             = bus.op2_rdy_in ? bus.op2_in : bus.cdb_result;
        new_entry_w.xer             = bus.xer_rdy_in ? bus.xer_in : bus.cdb_xer;
        new_entry_w.result_reg_addr = bus.result_reg_addr_in;
        new_entry_w.control         = bus.control_in;
        new_entry_w.age             = RS_AGE_MAX_W'(busy_cnt_w - CNT_W'(issue_fire_w));
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            entries_d[i] = entries_q[i];
            if (entries_q[i].busy) begin
                if (rs_cdb_hit(entries_q[i].op1_rdy, entries_q[i].op1_tag, bus.cdb_valid, cdb_tag_w)) begin
                    entries_d[i].op1     = bus.cdb_result;
                    entries_d[i].op1_rdy = 1'b1;
                end
                if (rs_cdb_hit(entries_q[i].op2_rdy, entries_q[i].op2_tag, bus.cdb_valid, cdb_tag_w)) begin
                    entries_d[i].op2     = bus.cdb_result;
                    entries_d[i].op2_rdy = 1'b1;
                end
                if (rs_cdb_hit(entries_q[i].xer_rdy, entries_q[i].xer_tag, bus.cdb_valid, cdb_tag_w)) begin
                    entries_d[i].xer     = bus.cdb_xer;
                    entries_d[i].xer_rdy = 1'b1;
                end
                if (issue_fire_w && (sel_idx_w == IDX_W'(i))) begin
                    entries_d[i].busy = 1'b0;
                end else if (issue_fire_w && (entries_q[i].age > sel_age_w)) begin
                    entries_d[i].age = entries_q[i].age - RS_AGE_MAX_W'(1);
                end
            end
        end
        if (dispatch_fire_w) begin
            entries_d[free_idx_w] = new_entry_w;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (rst) begin
                entries_q[i] <= '0;
            end else begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    assign bus.dispatch_ready      = free_found_w;
    assign bus.issue_valid         = sel_valid_w;
    assign bus.rs_id_out           = RS_ID_WIDTH'(RS_BASE_ID) + RS_ID_WIDTH'(sel_idx_w);
    assign bus.result_reg_addr_out = entries_q[sel_idx_w].result_reg_addr;
    assign bus.op1                 = entries_q[sel_idx_w].op1;
    assign bus.op2                 = entries_q[sel_idx_w].op2;
    assign bus.xer                 = entries_q[sel_idx_w].xer;
    assign bus.control             = entries_q[sel_idx_w].control;

endmodule
`default_nettype wire

// File: tb/tb_div_rs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_div_rs : directed and random checks of div_rs against a reference model
// ----------------------------------------------------------------------------
module tb_div_rs;
    import ppc_types::*;

    localparam int W    = 5;
    localparam int N    = 4;
    localparam int BASE = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_rs_if #(.RS_ID_WIDTH(W)) bus ();

    div_rs #(
        .RS_ID_WIDTH (W),
        .ENTRIES     (N),
        .RS_BASE_ID  (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: entries carry a dispatch sequence number; oldest = smallest.
    logic        m_busy [N];
    logic        m_rdy  [N][3];
    logic [W-1:0] m_tag [N][3];
    logic [31:0] m_val  [N][3];
    logic [4:0]  m_rd   [N];
    div_decode_t m_ctl  [N];
    int          m_seq  [N];
    int          next_seq = 0;
    bit          started  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick();
        int k;
        k = -1;
        for (int i = 0; i < N; i++) begin
            if (m_busy[i] && m_rdy[i][0] && m_rdy[i][1] && m_rdy[i][2] &&
                (k < 0 || m_seq[i] < m_seq[k])) k = i;
        end
        return k;
    endfunction

    always @(posedge clk) begin
        int k;
        int f;
        logic [31:0]  iv [3];
        logic         ir [3];
        logic [W-1:0] it [3];
        if (rst) begin
            started = 1'b1;
            for (int i = 0; i < N; i++) begin
                m_busy[i] = 1'b0;
                for (int j = 0; j < 3; j++) m_rdy[i][j] = 1'b0;
            end
        end else if (started) begin
            k = model_pick();
            f = -1;
            for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) f = i;
            for (int i = 0; i < N; i++) begin
                if (m_busy[i]) begin
                    for (int j = 0; j < 3; j++) begin
                        if (!m_rdy[i][j] && bus.cdb_valid && m_tag[i][j] == bus.cdb_rs_id) begin
                            m_rdy[i][j] = 1'b1;
                            m_val[i][j] = (j == 2) ? bus.cdb_xer : bus.cdb_result;
                        end
                    end
                end
            end
            if (k >= 0 && bus.issue_ready) m_busy[k] = 1'b0;
            if (bus.dispatch_valid && f >= 0) begin
                iv[0] = bus.op1_in;     ir[0] = bus.op1_rdy_in; it[0] = bus.op1_tag_in;
                iv[1] = bus.op2_in;     ir[1] = bus.op2_rdy_in; it[1] = bus.op2_tag_in;
                iv[2] = bus.xer_in;     ir[2] = bus.xer_rdy_in; it[2] = bus.xer_tag_in;
                m_busy[f] = 1'b1;
                m_seq[f]  = next_seq;
                next_seq++;
                m_rd[f]   = bus.result_reg_addr_in;
                m_ctl[f]  = bus.control_in;
                for (int j = 0; j < 3; j++) begin
                    m_tag[f][j] = it[j];
                    if (ir[j]) begin
                        m_rdy[f][j] = 1'b1;
                        m_val[f][j] = iv[j];
                    end else if (bus.cdb_valid && it[j] == bus.cdb_rs_id) begin
                        m_rdy[f][j] = 1'b1;
                        m_val[f][j] = (j == 2) ? bus.cdb_xer : bus.cdb_result;
                    end else begin
                        m_rdy[f][j] = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        int k;
        bit fr;
        if (started) begin
            k  = model_pick();
            fr = 1'b0;
            for (int i = 0; i < N; i++) if (!m_busy[i]) fr = 1'b1;
            chk("model_dispatch_ready", 32'(bus.dispatch_ready), 32'(fr));
            chk("model_issue_valid", 32'(bus.issue_valid), 32'(k >= 0));
            if (k >= 0) begin
                chk("model_rs_id_out", 32'(bus.rs_id_out), 32'(BASE + k));
                chk("model_result_reg_addr", 32'(bus.result_reg_addr_out), 32'(m_rd[k]));
                chk("model_op1", bus.op1, m_val[k][0]);
                chk("model_op2", bus.op2, m_val[k][1]);
                chk("model_xer", bus.xer, m_val[k][2]);
                chk("model_control", {28'd0, bus.control}, {28'd0, m_ctl[k]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dispatch_valid     = 1'b0;
        bus.result_reg_addr_in = 5'd0;
        bus.control_in         = '0;
        bus.op1_in = '0;  bus.op2_in = '0;  bus.xer_in = '0;
        bus.op1_rdy_in = 1'b0; bus.op2_rdy_in = 1'b0; bus.xer_rdy_in = 1'b0;
        bus.op1_tag_in = '0; bus.op2_tag_in = '0; bus.xer_tag_in = '0;
        bus.cdb_valid  = 1'b0; bus.cdb_rs_id = '0;
        bus.cdb_result = '0;   bus.cdb_xer   = '0;
    endtask

    task automatic disp(input logic [31:0] a, input logic ar, input logic [W-1:0] at,
                        input logic [31:0] b, input logic br, input logic [W-1:0] bt);
        bus.dispatch_valid     = 1'b1;
        bus.result_reg_addr_in = 5'd3;
        bus.control_in         = div_decode_t'(4'b0110);
        bus.op1_in = a; bus.op1_rdy_in = ar; bus.op1_tag_in = at;
        bus.op2_in = b; bus.op2_rdy_in = br; bus.op2_tag_in = bt;
        bus.xer_in = 32'd0; bus.xer_rdy_in = 1'b1; bus.xer_tag_in = '0;
    endtask

    initial begin
        rst = 1'b1;
        bus.issue_ready = 1'b0;
        idle();
        step();
        step();
        rst = 1'b0;
        chk("reset_issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("reset_dispatch_ready", 32'(bus.dispatch_ready), 32'd1);

        // All operands ready: visible the cycle after dispatch, freed the cycle after issue.
        disp(32'd100, 1'b1, 5'd0, 32'd7, 1'b1, 5'd0);
        bus.issue_ready = 1'b1;
        step(); idle();
        chk("ready_issue_valid", 32'(bus.issue_valid), 32'd1);
        chk("ready_op1", bus.op1, 32'd100);
        chk("ready_op2", bus.op2, 32'd7);
        chk("ready_rs_id", 32'(bus.rs_id_out), 32'(BASE));
        step();
        chk("ready_freed", 32'(bus.issue_valid), 32'd0);

        // op2 waits for tag 9 on the CDB.
        disp(32'd50, 1'b1, 5'd0, 32'd0, 1'b0, 5'd9);
        step(); idle();
        chk("wait_not_valid", 32'(bus.issue_valid), 32'd0);
        step();
        bus.cdb_valid = 1'b1; bus.cdb_rs_id = 5'd9; bus.cdb_result = 32'd3;
        step(); idle();
        chk("cdb_issue_valid", 32'(bus.issue_valid), 32'd1);
        chk("cdb_op2", bus.op2, 32'd3);
        chk("cdb_op1", bus.op1, 32'd50);
        step();
        chk("cdb_issued", 32'(bus.issue_valid), 32'd0);

        // Fill, reject a dispatch when full, free one entry.
        bus.issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(32'(10 + i), 1'b1, 5'd0, 32'(20 + i), 1'b1, 5'd0);
            step();
        end
        idle();
        chk("full_dispatch_ready", 32'(bus.dispatch_ready), 32'd0);
        disp(32'd999, 1'b1, 5'd0, 32'd999, 1'b1, 5'd0);
        step(); idle();
        chk("full_reject_ready", 32'(bus.dispatch_ready), 32'd0);
        chk("full_oldest_op1", bus.op1, 32'd10);
        bus.issue_ready = 1'b1;
        #1;
        chk("full_same_cycle_ready", 32'(bus.dispatch_ready), 32'd0);
        step();
        bus.issue_ready = 1'b0;
        chk("full_after_issue_ready", 32'(bus.dispatch_ready), 32'd1);
        chk("full_next_op1", bus.op1, 32'd11);
        chk("full_next_rs_id", 32'(bus.rs_id_out), 32'(BASE + 1));
        bus.issue_ready = 1'b1;
        step(); step(); step();
        bus.issue_ready = 1'b0;
        chk("full_drained", 32'(bus.issue_valid), 32'd0);

        // Older A sits in entry 1, younger B in entry 0; both wake on tag 3.
        disp(32'd5, 1'b1, 5'd0, 32'd6, 1'b1, 5'd0);
        step();
        disp(32'd0, 1'b0, 5'd3, 32'd1, 1'b1, 5'd0);
        step(); idle();
        bus.issue_ready = 1'b1;
        step();
        bus.issue_ready = 1'b0;
        disp(32'd0, 1'b0, 5'd3, 32'd2, 1'b1, 5'd0);
        step(); idle();
        bus.cdb_valid = 1'b1; bus.cdb_rs_id = 5'd3; bus.cdb_result = 32'd77;
        step(); idle();
        chk("age_first_rs_id", 32'(bus.rs_id_out), 32'(BASE + 1));
        chk("age_first_op2", bus.op2, 32'd1);
        chk("age_first_op1", bus.op1, 32'd77);
        bus.issue_ready = 1'b1;
        step();
        chk("age_second_rs_id", 32'(bus.rs_id_out), 32'(BASE));
        chk("age_second_op2", bus.op2, 32'd2);
        step();
        bus.issue_ready = 1'b0;
        chk("age_drained", 32'(bus.issue_valid), 32'd0);

        // Same-cycle bypass of the CDB into a dispatching entry.
        disp(32'd0, 1'b0, 5'd5, 32'd8, 1'b1, 5'd0);
        bus.cdb_valid = 1'b1; bus.cdb_rs_id = 5'd5; bus.cdb_result = 32'd42;
        step(); idle();
        chk("bypass_issue_valid", 32'(bus.issue_valid), 32'd1);
        chk("bypass_op1", bus.op1, 32'd42);
        bus.issue_ready = 1'b1;
        step();
        bus.issue_ready = 1'b0;
        chk("bypass_issued", 32'(bus.issue_valid), 32'd0);

        // Reset with three held entries.
        for (int i = 0; i < 3; i++) begin
            disp(32'(i), 1'b1, 5'd0, 32'(i + 1), 1'b1, 5'd0);
            step();
        end
        idle();
        chk("midrst_before_valid", 32'(bus.issue_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("midrst_dispatch_ready", 32'(bus.dispatch_ready), 32'd1);
        bus.issue_ready = 1'b1;
        step(); step();
        chk("midrst_no_stale", 32'(bus.issue_valid), 32'd0);

        // Random traffic against the model; small tag range keeps CDB hits frequent.
        for (int c = 0; c < 3000; c++) begin
            rst                    = ($urandom_range(0, 299) == 0);
            bus.dispatch_valid     = 1'($urandom_range(0, 1));
            bus.result_reg_addr_in = 5'($urandom);
            bus.control_in         = div_decode_t'(4'($urandom));
            bus.op1_in = $urandom; bus.op2_in = $urandom; bus.xer_in = $urandom;
            bus.op1_rdy_in = ($urandom_range(0, 2) != 0);
            bus.op2_rdy_in = ($urandom_range(0, 2) != 0);
            bus.xer_rdy_in = ($urandom_range(0, 2) != 0);
            bus.op1_tag_in = W'($urandom_range(0, 7));
            bus.op2_tag_in = W'($urandom_range(0, 7));
            bus.xer_tag_in = W'($urandom_range(0, 7));
            bus.cdb_valid  = 1'($urandom_range(0, 1));
            bus.cdb_rs_id  = W'($urandom_range(0, 7));
            bus.cdb_result = $urandom;
            bus.cdb_xer    = $urandom;
            bus.issue_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 1'b0;
        idle();
        bus.issue_ready = 1'b1;
        step(); step(); step(); step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
